// File: rtl/memory_dispatch_queue_pkg.sv
// Shared types and lane field layout for the memory dispatch queue.
// A lane is {op[14:0], addr, stridex, stridey}; lane 0 sits in the MSBs of a bundle.
package cherry_pkg;

  localparam int DEF_MAB = 15;
  localparam int OP_W    = 15;

  function automatic int lane_w(input int mab);
    return OP_W + 3 * mab;
  endfunction

  localparam int LANE_W      = lane_w(DEF_MAB);
  localparam int STRIDEY_LSB = 0;
  localparam int STRIDEX_LSB = DEF_MAB;
  localparam int ADDR_LSB    = 2 * DEF_MAB;
  localparam int OP_LSB      = 3 * DEF_MAB;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/memory_dispatch_queue_if.sv
// Push side (from control_unit) and per-lane issue side (to the load/store units).
interface memory_dispatch_queue_if #(
  parameter int MEMORY_ADDRESS_BITS   = 15,
  parameter int SUPERSCALAR_LOG_WIDTH = 2,
  parameter int QUEUE_LOG_DEPTH       = 2
);
  import cherry_pkg::*;

  localparam int SW = 1 << SUPERSCALAR_LOG_WIDTH;
  localparam int BW = lane_w(MEMORY_ADDRESS_BITS) * SW;

  logic                             flush;
  logic                             in_we;
  logic [BW-1:0]                    in_bundle;
  logic [SUPERSCALAR_LOG_WIDTH-1:0] in_copy_count;
  logic                             full;
  logic                             empty;
  logic [QUEUE_LOG_DEPTH:0]         occupancy;
  logic [SW-1:0]                    lane_valid;
  logic [BW-1:0]                    lane_data;
  logic [SW-1:0]                    lane_ready;
  logic                             overflow_error;

  modport master (
    output flush, in_we, in_bundle, in_copy_count, lane_ready,
    input  full, empty, occupancy, lane_valid, lane_data, overflow_error
  );

  modport slave (
    input  flush, in_we, in_bundle, in_copy_count, lane_ready,
    output full, empty, occupancy, lane_valid, lane_data, overflow_error
  );

endinterface

// File: rtl/memory_dispatch_queue_bundle_fifo.sv
// Bundle storage ring: pointers, occupancy count, full/empty.
// Storage is reset too so the head reads as zero out of reset.
module bundle_fifo #(
  parameter int DATA_W    = 62,
  parameter int LOG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   count
);
  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [LOG_DEPTH-1:0]         wr_ptr, rd_ptr;
  logic                         do_push, do_pop;

  assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memory_dispatch_queue.sv
// Buffers memory-instruction bundles and issues each active lane with its own valid/ready;
// a bundle retires once every active lane has handshaken.
module memory_dispatch_queue
  import cherry_pkg::*;
#(
  parameter int MEMORY_ADDRESS_BITS   = 15,
  parameter int SUPERSCALAR_LOG_WIDTH = 2,
  parameter int QUEUE_LOG_DEPTH       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  memory_dispatch_queue_if.slave   q
);
  localparam int SLW = SUPERSCALAR_LOG_WIDTH;
  localparam int SW  = 1 << SLW;
  localparam int BW  = lane_w(MEMORY_ADDRESS_BITS) * SW;
  localparam int EW  = BW + SLW;

  dispatch_state_t          state, state_nxt;
  logic [SW-1:0]            done_mask, active, hs, lane_valid;
  logic [EW-1:0]            head;
  logic [SLW-1:0]           head_cc;
  logic [QUEUE_LOG_DEPTH:0] count;
  logic                     push, pop, fifo_full, fifo_empty, overflow;

  // A pop never frees a slot for a same-cycle push: push sees the registered full.
  assign push    = q.in_we && !fifo_full && !q.flush;
  assign head_cc = head[SLW-1:0];

  // lane_valid depends on registers only; lane_ready only feeds handshake/pop.
  for (genvar i = 0; i < SW; i++) begin : g_lane
    assign active[i]     = (SLW'(i) <= head_cc);
    assign lane_valid[i] = (state == ISSUE) && active[i] && !done_mask[i];
    assign hs[i]         = lane_valid[i] && q.lane_ready[i];
  end

  assign pop = (state == ISSUE) && !q.flush && (((done_mask | hs) & active) == active);

  bundle_fifo #(
    .DATA_W    (EW),
    .LOG_DEPTH (QUEUE_LOG_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (q.flush),
    .push    (push),
    .pop     (pop),
    .wr_data ({q.in_bundle, q.in_copy_count}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done_mask <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (q.flush || pop) done_mask <= '0;
      else                done_mask <= done_mask | hs;
      if (q.in_we && fifo_full && !q.flush) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = ISSUE;
      ISSUE: begin
        if (q.flush) state_nxt = IDLE;
        else if (pop && count == (QUEUE_LOG_DEPTH+1)'(1) && !push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign q.lane_valid     = lane_valid;
  assign q.lane_data      = head[EW-1:SLW];
  assign q.full           = fifo_full;
  assign q.empty          = fifo_empty;
  assign q.occupancy      = count;
  assign q.overflow_error = overflow;

endmodule

// File: tb/tb_memory_dispatch_queue.sv
// Directed bench for memory_dispatch_queue; pushed bundles go to a scoreboard and are
// compared against lane_data/lane_valid when they reach the head.
module tb_memory_dispatch_queue;
  import cherry_pkg::*;

  localparam int MAB = 15;
  localparam int SLW = 2;
  localparam int QLD = 2;
  localparam int SW  = 1 << SLW;
  localparam int LW  = lane_w(MAB);
  localparam int BW  = LW * SW;

  typedef struct {
    logic [BW-1:0]  b;
    logic [SLW-1:0] cc;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  ent_t sb[$];

  memory_dispatch_queue_if #(.MEMORY_ADDRESS_BITS(MAB), .SUPERSCALAR_LOG_WIDTH(SLW),
                             .QUEUE_LOG_DEPTH(QLD)) q ();

  memory_dispatch_queue #(.MEMORY_ADDRESS_BITS(MAB), .SUPERSCALAR_LOG_WIDTH(SLW),
                          .QUEUE_LOG_DEPTH(QLD)) dut (
    .clk   (clk),
    .reset (rst_n),
    .q     (q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] amask(input logic [SLW-1:0] cc);
    logic [SW-1:0] m = '0;
    for (int i = 0; i < SW; i++) if (i <= int'(cc)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [BW-1:0] mk(input int tag);
    logic [BW-1:0] b = '0;
    logic [LW-1:0] l;
    for (int i = 0; i < SW; i++) begin
      l = '0;
      l[OP_LSB +: 15]      = 15'(tag * 4 + i);
      l[ADDR_LSB +: MAB]   = MAB'($urandom);
      l[STRIDEX_LSB +: MAB] = MAB'($urandom);
      l[STRIDEY_LSB +: MAB] = MAB'($urandom);
      b[(SW-1-i)*LW +: LW] = l;
    end
    return b;
  endfunction

  task automatic push_b(input int tag, input logic [SLW-1:0] cc, input bit acc);
    ent_t e;
    e.b = mk(tag);
    e.cc = cc;
    q.in_we = 1'b1;
    q.in_bundle = e.b;
    q.in_copy_count = cc;
    if (acc) sb.push_back(e);
    tick();
    q.in_we = 1'b0;
  endtask

  // Head of the DUT must match the oldest scoreboard entry.
  task automatic issue_chk(input string tag);
    ent_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty observed=%0h expected=none", tag, q.lane_data);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, q.lane_data, e.b);
      chk({tag, "_valid"}, BW'(q.lane_valid), BW'(amask(e.cc)));
    end
  endtask

  initial begin
    logic [LW-1:0] l0;
    int t;
    q.flush = 1'b0;
    q.in_we = 1'b0;
    q.in_bundle = '0;
    q.in_copy_count = '0;
    q.lane_ready = '0;

    // Reset state
    tick(); tick();
    chk("rst_empty", BW'(q.empty), BW'(1));
    chk("rst_full", BW'(q.full), BW'(0));
    chk("rst_occ", BW'(q.occupancy), BW'(0));
    chk("rst_valid", BW'(q.lane_valid), BW'(0));
    chk("rst_data", q.lane_data, '0);
    chk("rst_ovf", BW'(q.overflow_error), BW'(0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", BW'(q.lane_valid), BW'(0));

    // 1: four lanes, all ready -> issue next cycle, retire same cycle
    q.lane_ready = 4'b1111;
    push_b(1, 2'd3, 1'b1);
    l0 = q.lane_data[BW-1 -: LW];
    chk("t1_lane0_op", BW'(l0[OP_LSB +: 15]), BW'(15'(4)));
    issue_chk("t1");
    tick();
    chk("t1_empty", BW'(q.empty), BW'(1));
    chk("t1_valid_after", BW'(q.lane_valid), BW'(0));

    // 2: two lanes completing out of order over several cycles
    q.lane_ready = 4'b0000;
    push_b(2, 2'd1, 1'b1);
    issue_chk("t2");
    q.lane_ready = 4'b0010;
    tick();
    q.lane_ready = 4'b0000;
    chk("t2_valid_lane0", BW'(q.lane_valid), BW'(4'b0001));
    tick(); tick();
    chk("t2_valid_hold", BW'(q.lane_valid), BW'(4'b0001));
    chk("t2_occ_hold", BW'(q.occupancy), BW'(1));
    q.lane_ready = 4'b0001;
    tick();
    q.lane_ready = 4'b0000;
    chk("t2_empty", BW'(q.empty), BW'(1));
    chk("t2_valid_after", BW'(q.lane_valid), BW'(0));

    // 3: overfill, then drain in order
    chk("t3_ovf_clear", BW'(q.overflow_error), BW'(0));
    for (int k = 0; k < 5; k++) begin
      push_b(30 + k, SLW'(k % 4), k < 4);
      if (k == 3) begin
        chk("t3_full", BW'(q.full), BW'(1));
        chk("t3_occ4", BW'(q.occupancy), BW'(4));
        chk("t3_ovf_before", BW'(q.overflow_error), BW'(0));
      end
    end
    chk("t3_ovf", BW'(q.overflow_error), BW'(1));
    chk("t3_occ_after", BW'(q.occupancy), BW'(4));
    q.lane_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      issue_chk($sformatf("t3_drain%0d", k));
      tick();
    end
    q.lane_ready = 4'b0000;
    chk("t3_empty", BW'(q.empty), BW'(1));

    // 4: push while full and head retiring is rejected, accepted the cycle after
    for (int k = 0; k < 4; k++) push_b(40 + k, 2'd0, 1'b1);
    issue_chk("t4_head");
    q.lane_ready = 4'b1111;
    push_b(44, 2'd0, 1'b0);
    q.lane_ready = 4'b0000;
    chk("t4_occ3", BW'(q.occupancy), BW'(3));
    chk("t4_notfull", BW'(q.full), BW'(0));
    push_b(45, 2'd0, 1'b1);
    chk("t4_occ4", BW'(q.occupancy), BW'(4));
    q.lane_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      issue_chk($sformatf("t4_drain%0d", k));
      tick();
    end
    chk("t4_empty", BW'(q.empty), BW'(1));

    // 5: full-throughput streaming across pointer wrap
    for (int k = 0; k < 10; k++) begin
      push_b(50 + k, 2'd0, 1'b1);
      issue_chk($sformatf("t5_%0d", k));
      chk($sformatf("t5_occ%0d", k), BW'(q.occupancy), BW'(1));
    end
    tick();
    chk("t5_empty", BW'(q.empty), BW'(1));

    // 6: flush with a half-done head plus a same-cycle push
    q.lane_ready = 4'b0000;
    push_b(60, 2'd3, 1'b1);
    issue_chk("t6");
    q.lane_ready = 4'b0101;
    tick();
    chk("t6_partial", BW'(q.lane_valid), BW'(4'b1010));
    q.flush = 1'b1;
    q.lane_ready = 4'b1010;
    push_b(61, 2'd3, 1'b0);
    q.flush = 1'b0;
    q.lane_ready = 4'b0000;
    chk("t6_empty", BW'(q.empty), BW'(1));
    chk("t6_valid", BW'(q.lane_valid), BW'(0));
    chk("t6_occ", BW'(q.occupancy), BW'(0));
    tick();
    chk("t6_still_empty", BW'(q.empty), BW'(1));
    push_b(62, 2'd3, 1'b1);
    issue_chk("t6_fresh");

    // Reset mid-issue drops the partial bundle
    q.lane_ready = 4'b0011;
    tick();
    q.lane_ready = 4'b0000;
    chk("rst_mid_partial", BW'(q.lane_valid), BW'(4'b1100));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", BW'(q.lane_valid), BW'(0));
    chk("rst_mid_ovf", BW'(q.overflow_error), BW'(0));
    sb.delete();
    tick();
    rst_n = 1'b1;
    t = 0;
    repeat (2) begin
      tick();
      t++;
      chk($sformatf("rst_rel_valid%0d", t), BW'(q.lane_valid), BW'(0));
    end
    chk("rst_rel_empty", BW'(q.empty), BW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
